// File: rtl/writeback_port.sv
`default_nettype none
// ============================================================================
// writeback_port : 4-entry in-order writeback FIFO replaying ALU/load results
//                  to the register file with a setup-then-strobe write cycle.
// Revision       : 1.0
// ============================================================================
module writeback_port (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic [4:0]  RW,
    output logic [31:0] BusW,
    output logic        sig_enable_write,
    input  logic [4:0]  query_ra,
    input  logic [4:0]  query_rb,
    output logic        pend_a,
    output logic        pend_b,
    output logic [2:0]  count,
    output logic        idle
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  count_q, count_d;
    logic [1:0]  head_q, head_d;
    logic [1:0]  tail_q, tail_d;
    logic [4:0]  rw_q, rw_d;
    logic [31:0] busw_q, busw_d;
    logic [4:0]  rd_q   [4];
    logic [4:0]  rd_d   [4];
    logic [31:0] data_q [4];
    logic [31:0] data_d [4];

    logic        mem_push, alu_push, pop;
    logic [1:0]  alu_slot;
    logic [3:0]  ent_valid;
    logic [1:0]  ent_off;
    logic        hit_a, hit_b;

    // Readies look only at the registered count so they never depend on pop.
    always_comb begin
        mem_ready = !reset && (count_q < 3'd4);
        alu_ready = !reset && ((count_q <= 3'd2) || ((count_q == 3'd3) && !mem_valid));
        mem_push  = mem_valid && mem_ready && (mem_rd != 5'd0);
        alu_push  = alu_valid && alu_ready && (alu_rd != 5'd0);
        pop       = (state_q != SETUP) && (count_q != 3'd0);
        alu_slot  = tail_q + {1'b0, mem_push};
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        rw_d    = rw_q;
        busw_d  = busw_q;
        rd_d    = rd_q;
        data_d  = data_q;

        case (state_q)
            IDLE:    state_d = pop ? SETUP : IDLE;
            SETUP:   state_d = STROBE;
            STROBE:  state_d = pop ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase

        if (pop) begin
            rw_d   = rd_q[head_q];
            busw_d = data_q[head_q];
            head_d = head_q + 2'd1;
        end

        // The load result takes the older slot when both land together.
        if (mem_push) begin
            rd_d[tail_q]   = mem_rd;
            data_d[tail_q] = mem_data;
        end
        if (alu_push) begin
            rd_d[alu_slot]   = alu_rd;
            data_d[alu_slot] = alu_data;
        end
        tail_d  = tail_q + {1'b0, mem_push} + {1'b0, alu_push};
        count_d = count_q + {2'b00, mem_push} + {2'b00, alu_push} - {2'b00, pop};
    end

    always_comb begin
        hit_a   = 1'b0;
        hit_b   = 1'b0;
        ent_off = 2'd0;
        for (int i = 0; i < 4; i++) begin
            ent_off      = 2'(i) - head_q;
            ent_valid[i] = ({1'b0, ent_off} < count_q);
            hit_a        = hit_a | (ent_valid[i] && (rd_q[i] == query_ra));
            hit_b        = hit_b | (ent_valid[i] && (rd_q[i] == query_rb));
        end
        // The entry held in RW is still pending until its strobe cycle ends.
        hit_a  = hit_a | ((state_q != IDLE) && (rw_q == query_ra));
        hit_b  = hit_b | ((state_q != IDLE) && (rw_q == query_rb));
        pend_a = (query_ra != 5'd0) && hit_a;
        pend_b = (query_rb != 5'd0) && hit_b;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= 3'd0;
            head_q  <= 2'd0;
            tail_q  <= 2'd0;
            rw_q    <= 5'd0;
            busw_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            rw_q    <= rw_d;
            busw_q  <= busw_d;
        end
    end

    // Entry storage needs no reset; validity comes from head/count.
    always_ff @(posedge clock) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end

    assign RW               = rw_q;
    assign BusW             = busw_q;
    assign sig_enable_write = (state_q == STROBE);
    assign count            = count_q;
    assign idle             = (state_q == IDLE) && (count_q == 3'd0);

endmodule
`default_nettype wire

// File: tb/tb_writeback_port.sv
`default_nettype none
// ============================================================================
// tb_writeback_port : directed self-checking bench for writeback_port.
// Revision          : 1.0
// ============================================================================
module tb_writeback_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic [4:0]  RW;
    logic [31:0] BusW;
    logic        sig_enable_write;
    logic [4:0]  query_ra, query_rb;
    logic        pend_a, pend_b;
    logic [2:0]  count;
    logic        idle;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [4:0]  wr_rd   [$];
    logic [31:0] wr_data [$];
    int          wr_cyc  [$];

    always #5 clk = ~clk;

    writeback_port dut (
        .clock(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .RW(RW), .BusW(BusW), .sig_enable_write(sig_enable_write),
        .query_ra(query_ra), .query_rb(query_rb), .pend_a(pend_a), .pend_b(pend_b),
        .count(count), .idle(idle)
    );

    // Log every register-file write with the cycle of its strobe.
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (sig_enable_write) begin
            wr_rd.push_back(RW);
            wr_data.push_back(BusW);
            wr_cyc.push_back(cycle);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while (!idle && n < 100) begin
            tick;
            n++;
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL wait_idle: idle=%b after %0d cycles, required 1", idle, n);
        end
    endtask

    task automatic test_reset;
        clear_inputs;
        query_ra = 5'd0; query_rb = 5'd0;
        reset = 1'b1;
        tick; tick;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", count); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b, required 1", idle); end
        checks++; if (RW !== 5'd0 || BusW !== 32'd0) begin errors++; $display("FAIL reset_rw_busw: got %0d/%h, required 0/0", RW, BusW); end
        checks++; if (sig_enable_write !== 1'b0) begin errors++; $display("FAIL reset_we: got %b, required 0", sig_enable_write); end
        alu_valid = 1'b1; mem_valid = 1'b1;
        #1;
        checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin errors++; $display("FAIL reset_readies: got alu=%b mem=%b, required 0/0", alu_ready, mem_ready); end
        clear_inputs;
        reset = 1'b0;
        tick;
        checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin errors++; $display("FAIL post_reset_readies: got alu=%b mem=%b, required 1/1", alu_ready, mem_ready); end
    endtask

    task automatic test_single_write;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick;
        clear_inputs;
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d, required 1", count); end
        tick;
        checks++; if (RW !== 5'd5 || BusW !== 32'hDEADBEEF || sig_enable_write !== 1'b0) begin
            errors++; $display("FAIL single_setup: got RW=%0d BusW=%h we=%b, required 5/deadbeef/0", RW, BusW, sig_enable_write); end
        tick;
        checks++; if (sig_enable_write !== 1'b1 || RW !== 5'd5) begin errors++; $display("FAIL single_strobe: got we=%b RW=%0d, required 1/5", sig_enable_write, RW); end
        tick;
        checks++; if (sig_enable_write !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL single_done: got we=%b idle=%b, required 0/1", sig_enable_write, idle); end
        checks++; if (RW !== 5'd5 || BusW !== 32'hDEADBEEF) begin errors++; $display("FAIL single_retain: got %0d/%h, required 5/deadbeef", RW, BusW); end
    endtask

    task automatic test_r0_discard;
        int start;
        start = wr_rd.size();
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h1234;
        #1;
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL r0_ready: got %b, required 1", mem_ready); end
        tick;
        clear_inputs;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL r0_count: got %0d, required 0", count); end
        repeat (4) tick;
        checks++; if (wr_rd.size() != start) begin errors++; $display("FAIL r0_pulse: got %0d writes, required 0", wr_rd.size() - start); end
    endtask

    task automatic test_dual_offer;
        int start;
        logic [4:0] exp_rd [6];
        exp_rd = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd8};
        wait_idle;
        start = wr_rd.size();
        mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'h1001;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h1002;
        tick;
        mem_rd = 5'd3; mem_data = 32'h1003;
        alu_rd = 5'd4; alu_data = 32'h1004;
        tick;
        clear_inputs;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL dual_fill: got count %0d, required 3", count); end
        tick;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1007;
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h1008;
        #1;
        checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
            errors++; $display("FAIL dual_arb: got mem=%b alu=%b, required 1/0", mem_ready, alu_ready); end
        tick;
        mem_valid = 1'b0;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL dual_alu_next: got %b, required 1", alu_ready); end
        tick;
        clear_inputs;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL dual_full: got count %0d, required 4", count); end
        wait_idle;
        checks++; if (wr_rd.size() - start != 6) begin errors++; $display("FAIL dual_nwrites: got %0d, required 6", wr_rd.size() - start); end
        for (int k = 0; k < 6 && start + k < wr_rd.size(); k++) begin
            checks++;
            if (wr_rd[start+k] !== exp_rd[k] || wr_data[start+k] !== (32'h1000 + 32'(exp_rd[k]))) begin
                errors++; $display("FAIL dual_order[%0d]: got %0d/%h, required %0d/%h", k, wr_rd[start+k], wr_data[start+k], exp_rd[k], 32'h1000 + 32'(exp_rd[k]));
            end
        end
    endtask

    task automatic test_burst;
        int start, n, guard;
        logic acc;
        wait_idle;
        start = wr_rd.size();
        n = 1; guard = 0;
        while (n <= 6 && guard < 100) begin
            alu_valid = 1'b1; alu_rd = 5'(n); alu_data = 32'hA000_0000 + 32'(n);
            #1;
            checks++;
            if (alu_ready !== (count != 3'd4)) begin
                errors++; $display("FAIL burst_ready: got %b at count %0d, required %b", alu_ready, count, count != 3'd4);
            end
            acc = alu_ready;
            tick;
            if (acc) n++;
            guard++;
        end
        clear_inputs;
        wait_idle;
        checks++; if (wr_rd.size() - start != 6) begin errors++; $display("FAIL burst_nwrites: got %0d, required 6", wr_rd.size() - start); end
        for (int k = 0; k < 6 && start + k < wr_rd.size(); k++) begin
            checks++;
            if (wr_rd[start+k] !== 5'(k + 1) || wr_data[start+k] !== 32'hA000_0000 + 32'(k + 1)) begin
                errors++; $display("FAIL burst_order[%0d]: got %0d/%h, required %0d/%h", k, wr_rd[start+k], wr_data[start+k], k + 1, 32'hA000_0000 + 32'(k + 1));
            end
            if (k > 0) begin
                checks++;
                if (wr_cyc[start+k] - wr_cyc[start+k-1] != 2) begin
                    errors++; $display("FAIL burst_spacing[%0d]: got %0d cycles, required 2", k, wr_cyc[start+k] - wr_cyc[start+k-1]);
                end
            end
        end
    endtask

    task automatic test_hazard;
        logic exp_a [4];
        exp_a = '{1'b1, 1'b1, 1'b1, 1'b0};
        wait_idle;
        query_ra = 5'd9; query_rb = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9999;
        tick;
        clear_inputs;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (pend_a !== exp_a[k] || pend_b !== 1'b0) begin
                errors++; $display("FAIL hazard[%0d]: got pend_a=%b pend_b=%b, required %b/0", k, pend_a, pend_b, exp_a[k]);
            end
            tick;
        end
        query_ra = 5'd0;
    endtask

    task automatic test_reset_mid;
        int start;
        wait_idle;
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hA;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hB;
        tick;
        mem_valid = 1'b0; alu_rd = 5'd12; alu_data = 32'hC;
        tick;
        clear_inputs;
        checks++; if (RW !== 5'd10 || sig_enable_write !== 1'b0 || count !== 3'd2) begin
            errors++; $display("FAIL rmid_setup: got RW=%0d we=%b count=%0d, required 10/0/2", RW, sig_enable_write, count); end
        start = wr_rd.size();
        query_ra = 5'd11;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++; if (count !== 3'd0 || RW !== 5'd0 || BusW !== 32'd0 || idle !== 1'b1 || sig_enable_write !== 1'b0) begin
            errors++; $display("FAIL rmid_after: got count=%0d RW=%0d BusW=%h idle=%b we=%b, required 0/0/0/1/0", count, RW, BusW, idle, sig_enable_write); end
        checks++; if (pend_a !== 1'b0) begin errors++; $display("FAIL rmid_pend: got %b, required 0", pend_a); end
        repeat (6) tick;
        checks++; if (wr_rd.size() != start) begin errors++; $display("FAIL rmid_pulse: got %0d writes, required 0", wr_rd.size() - start); end
        query_ra = 5'd0;
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_r0_discard;
        test_dual_offer;
        test_burst;
        test_hazard;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_port.md
WRITEBACK_PORT -- requirements
Module: writeback_port

Interface
REQ-001 SHALL have no parameters; depth fixed at 4 entries, data 32 bits, register index 5 bits.
REQ-002 SHALL provide these ports:
- clock  in  1  sole clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result offered
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result value
- alu_ready  out  1  ALU offer accepted this cycle when high with alu_valid
- mem_valid  in  1  load result offered
- mem_rd  in  5  load destination register
- mem_data  in  32  load result value
- mem_ready  out  1  load offer accepted this cycle when high with mem_valid
- RW  out  5  register-file write select
- BusW  out  32  register-file write data
- sig_enable_write  out  1  register-file write strobe; the file writes on its rising edge
- query_ra  in  5  hazard query A
- query_rb  in  5  hazard query B
- pend_a  out  1  write to query_ra still pending
- pend_b  out  1  write to query_rb still pending
- count  out  3  FIFO occupancy, 0..4
- idle  out  1  FIFO empty and FSM in IDLE

Function
REQ-003 SHALL buffer accepted results in a 4-entry in-order FIFO and replay each to the register file as one write.
REQ-004 SHALL compute readies from the registered count only: mem_ready = (count<4); alu_ready = (count<=2) or (count==3 and not mem_valid).
REQ-005 SHALL enqueue both results in the same cycle when both are handshaken, mem entry older than alu entry.
REQ-006 SHALL accept but not store any offer with rd==0 (no FIFO entry, no write, count unchanged).
REQ-007 SHALL update count as count + enqueues - dequeue in the same cycle; simultaneous enqueue and dequeue is legal.
REQ-008 SHALL implement FSM states IDLE, SETUP, STROBE.
REQ-009 IDLE: sig_enable_write=0; if count>0, pop head into RW/BusW and go to SETUP; else stay.
REQ-010 SETUP: RW/BusW held stable, sig_enable_write=0; go to STROBE unconditionally.
REQ-011 STROBE: RW/BusW held, sig_enable_write=1 for exactly this cycle; if count>0, pop head into RW/BusW and go to SETUP; else go to IDLE.
REQ-012 SHALL guarantee RW/BusW are stable for a full cycle before every rising edge of sig_enable_write and remain stable while it is high.
REQ-013 Latency: entry accepted at edge N into an empty, IDLE block -> RW/BusW valid after edge N+1; sig_enable_write high after edge N+2 for one cycle.
REQ-014 Throughput: one write per 2 cycles sustained; never two consecutive cycles with sig_enable_write high.
REQ-015 RW/BusW SHALL retain the last written values in IDLE.
REQ-016 pend_a (combinational) SHALL be 1 iff query_ra!=0 and query_ra matches any valid FIFO entry rd or RW while in SETUP/STROBE; pend_b likewise for query_rb.
REQ-017 pend_a/pend_b SHALL drop in the cycle after the last matching STROBE.
REQ-018 idle SHALL equal (state==IDLE and count==0).

Reset
REQ-019 On reset high at an edge: state=IDLE, count=0, FIFO entries invalid, RW=0, BusW=0, sig_enable_write=0, pend_a/pend_b=0.
REQ-020 Reset mid-operation SHALL discard all buffered and in-flight writes; sig_enable_write SHALL be low the cycle after reset is sampled, even if STROBE was pending.
REQ-021 Readies SHALL be low while reset is high.

Verification
REQ-022 Single write: alu_valid, rd=5, data=0xDEADBEEF at edge 1 -> RW=5/BusW=0xDEADBEEF after edge 2, sig_enable_write=1 after edge 3 only, idle=1 after edge 4.
REQ-023 R0 discard: mem_valid, rd=0, data=0x1234 -> mem_ready=1, count stays 0, no sig_enable_write pulse.
REQ-024 Dual offer at count=3: mem (rd=7) and alu (rd=8) both valid -> mem accepted, alu_ready=0; next cycle alu accepted; writes issue in order 7 then 8.
REQ-025 Burst of 6 ALU results rd=1..6 -> alu_ready deasserts at count=4, writes issue 1..6 in order, pulses exactly 2 cycles apart, no data loss.
REQ-026 Hazard: enqueue rd=9, query_ra=9, query_rb=0 -> pend_a=1 until cycle after its STROBE, pend_b=0 throughout.
REQ-027 Reset during SETUP with 2 entries queued -> no further pulses, count=0, RW=0, BusW=0, idle=1 after the reset edge.
